// File: rtl/shim_spi_sts_sync_pkg.sv
// Shared definitions for the SPI-side status return path: FSM encoding,
// status word layout and the default sticky mask derived from it.
package shim_spi_sts_sync_pkg;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_WAIT_ACK = 1'b1
  } sts_state_e;

  // Status word layout: level flags in the low half, event strobes above.
  localparam int STS_STK_LSB = 16;
  localparam int STS_STK_W   = 16;

  localparam logic [31:0] STICKY_MASK_DEF = {{STS_STK_W{1'b1}}, {STS_STK_LSB{1'b0}}};

  localparam int CCNT_W = 8;

  // Saturating increment for the coalesce counter.
  function automatic logic [CCNT_W-1:0] sat_inc(input logic [CCNT_W-1:0] v);
    return (v == {CCNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/shim_toggle_sync.sv
// Multi-flop synchronizer for a single toggle-encoded control bit.
module shim_toggle_sync #(
  parameter int SYNC_DEPTH = 3
) (
  input  logic spi_clk,
  input  logic spi_reset,
  input  logic d,
  output logic q
);

  logic [SYNC_DEPTH-1:0] chain;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge spi_clk or posedge spi_reset) begin
    if (spi_reset) chain <= '0;
    else           chain <= {chain[SYNC_DEPTH-2:0], d};
  end

  assign q = chain[SYNC_DEPTH-1];

endmodule

// File: rtl/shim_spi_sts_sync.sv
// SPI-domain transmit side of the status return path. Snapshots level flags
// and accumulated event strobes, holds them stable and hands them to the AXI
// domain over a toggle req/ack handshake.
module shim_spi_sts_sync
  import shim_spi_sts_sync_pkg::*;
#(
  parameter int                   STS_WIDTH      = 32,
  parameter logic [STS_WIDTH-1:0] STICKY_MASK    = STS_WIDTH'(STICKY_MASK_DEF),
  parameter int                   SYNC_DEPTH     = 3,
  parameter int                   TIMEOUT_CYCLES = 1024
) (
  input  logic                 spi_clk,
  input  logic                 spi_reset,
  input  logic [STS_WIDTH-1:0] sts_in,
  output logic [STS_WIDTH-1:0] sts_data_out,
  output logic                 sts_req_toggle,
  input  logic                 sts_ack_toggle,
  output logic                 busy,
  output logic                 ack_timeout,
  output logic [CCNT_W-1:0]    coalesce_count,
  input  logic                 coalesce_clr
);

  localparam logic [STS_WIDTH-1:0] LVL_MASK = ~STICKY_MASK;
  localparam int                   TW       = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0]        T_LAST   = TW'(TIMEOUT_CYCLES - 1);

  sts_state_e           state, state_nxt;
  logic [STS_WIDTH-1:0] sts_q, sts_q_prev, sticky_acc, sticky_new, snapshot;
  logic [TW-1:0]        timer, timer_inc;
  logic                 ack_s, pending, capture, acked, level_chg, dirty;

  shim_toggle_sync #(.SYNC_DEPTH(SYNC_DEPTH)) u_ack_sync (
    .spi_clk   (spi_clk),
    .spi_reset (spi_reset),
    .d         (sts_ack_toggle),
    .q         (ack_s)
  );

  // Strobes seen this cycle join the accumulator; the snapshot carries both,
  // so a strobe landing on the capture edge is sent once and not re-queued.
  assign sticky_new = sticky_acc | (sts_q & STICKY_MASK);
  assign snapshot   = (sts_q & LVL_MASK) | sticky_new;
  assign pending    = (((snapshot ^ sts_data_out) & LVL_MASK) != '0) || (sticky_new != '0);
  assign level_chg  = ((sts_q ^ sts_q_prev) & LVL_MASK) != '0;
  assign timer_inc  = (timer == T_LAST) ? timer : timer + 1'b1;
  assign busy       = (state == ST_WAIT_ACK);

  // State register.
  always_ff @(posedge spi_clk or posedge spi_reset) begin
    if (spi_reset) state <= ST_IDLE;
    else           state <= state_nxt;
  end

  // Next state: capture when anything is pending, release on matching ack.
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    acked     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (pending) begin
          capture   = 1'b1;
          state_nxt = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        if (ack_s == sts_req_toggle) begin
          acked     = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
    endcase
  end

  // Input register, strobe accumulator, snapshot/req and ack watchdog.
  always_ff @(posedge spi_clk or posedge spi_reset) begin
    if (spi_reset) begin
      sts_q          <= '0;
      sts_q_prev     <= '0;
      sticky_acc     <= '0;
      sts_data_out   <= '0;
      sts_req_toggle <= 1'b0;
      timer          <= '0;
      ack_timeout    <= 1'b0;
    end else begin
      sts_q      <= sts_in;
      sts_q_prev <= sts_q;
      sticky_acc <= capture ? '0 : sticky_new;
      if (capture) begin
        sts_data_out   <= snapshot;
        sts_req_toggle <= ~sts_req_toggle;
        timer          <= '0;
      end else if (busy && !acked) begin
        timer <= timer_inc;
        if (timer_inc == T_LAST) ack_timeout <= 1'b1;
      end
    end
  end

  // Count level updates that were overtaken while a snapshot was in flight.
  always_ff @(posedge spi_clk or posedge spi_reset) begin
    if (spi_reset) begin
      dirty          <= 1'b0;
      coalesce_count <= '0;
    end else begin
      if (capture)                dirty <= 1'b0;
      else if (busy && level_chg) dirty <= 1'b1;
      if (coalesce_clr)
        coalesce_count <= '0;
      else if (busy && level_chg && dirty)
        coalesce_count <= sat_inc(coalesce_count);
    end
  end

endmodule

// File: tb/tb_shim_spi_sts_sync.sv
// Directed bench: expected snapshots go into a scoreboard queue as stimulus
// is applied; a monitor pops one on every req toggle and checks sts_data_out.
module tb_shim_spi_sts_sync;

  localparam int SYNC_DEPTH = 3;
  localparam int TMO        = 16;

  logic        spi_clk = 1'b0;
  logic        spi_reset;
  logic [31:0] sts_in;
  logic [31:0] sts_data_out;
  logic        sts_req_toggle;
  logic        sts_ack_toggle;
  logic        busy;
  logic        ack_timeout;
  logic [7:0]  coalesce_count;
  logic        coalesce_clr;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] sb[$];
  logic        last_req = 1'b0;
  logic        saved_req;

  shim_spi_sts_sync #(
    .STS_WIDTH      (32),
    .SYNC_DEPTH     (SYNC_DEPTH),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .spi_clk        (spi_clk),
    .spi_reset      (spi_reset),
    .sts_in         (sts_in),
    .sts_data_out   (sts_data_out),
    .sts_req_toggle (sts_req_toggle),
    .sts_ack_toggle (sts_ack_toggle),
    .busy           (busy),
    .ack_timeout    (ack_timeout),
    .coalesce_count (coalesce_count),
    .coalesce_clr   (coalesce_clr)
  );

  always #5 spi_clk = ~spi_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge spi_clk);
    #1;
  endtask

  // AXI-side receiver: toggle ack, then busy must drop SYNC_DEPTH+1 edges later.
  task automatic do_ack(input string tag);
    int n;
    sts_ack_toggle = ~sts_ack_toggle;
    n = 0;
    while (busy && n < 32) begin
      tick();
      n++;
    end
    check(tag, 32'(n), 32'(SYNC_DEPTH + 1));
  endtask

  // Scoreboard monitor: each req toggle outside reset consumes one expected word.
  always @(posedge spi_clk) begin
    logic [31:0] exp;
    #2;
    if (spi_reset) begin
      last_req = 1'b0;
    end else if (sts_req_toggle !== last_req) begin
      last_req = sts_req_toggle;
      exp = (sb.size() != 0) ? sb.pop_front() : 32'hxxxx_xxxx;
      check("sb_send", sts_data_out, exp);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    // Reset with all-ones input.
    spi_reset = 1'b1; sts_in = 32'hFFFF_FFFF; sts_ack_toggle = 1'b0; coalesce_clr = 1'b0;
    repeat (3) tick();
    check("rst_data",  sts_data_out, 32'h0);
    check("rst_req",   32'(sts_req_toggle), 32'h0);
    check("rst_busy",  32'(busy), 32'h0);
    check("rst_tmo",   32'(ack_timeout), 32'h0);
    check("rst_ccnt",  32'(coalesce_count), 32'h0);

    // First capture after release; levels then drop to 0, which is resent.
    sb.push_back(32'hFFFF_FFFF);
    sb.push_back(32'h0000_0000);
    spi_reset = 1'b0;
    tick();
    check("rel_lat_req", 32'(sts_req_toggle), 32'h0);
    sts_in = 32'h0;
    tick();
    check("rel_req",  32'(sts_req_toggle), 32'h1);
    check("rel_data", sts_data_out, 32'hFFFF_FFFF);
    do_ack("rel_ack_lat");
    tick();
    check("resend0_busy", 32'(busy), 32'h1);
    do_ack("resend0_ack_lat");
    repeat (3) tick();
    check("idle_quiet", 32'(busy), 32'h0);

    // Level send: two-edge latency.
    sb.push_back(32'h0000_0005);
    sts_in = 32'h5;
    tick();
    check("lvl_lat_busy", 32'(busy), 32'h0);
    tick();
    check("lvl_data", sts_data_out, 32'h5);
    check("lvl_req",  32'(sts_req_toggle), 32'h1);
    check("lvl_busy", 32'(busy), 32'h1);

    // Sticky strobe during WAIT_ACK, levels back to 0.
    tick();
    sts_in = 32'h0001_0000;
    tick();
    sts_in = 32'h0;
    sb.push_back(32'h0001_0000);
    do_ack("lvl_ack_lat");
    tick();
    check("stk_data", sts_data_out, 32'h0001_0000);

    // Coalesce: 0->1->2->3 while busy = one dirty mark plus two merges.
    sts_in = 32'h1; tick();
    sts_in = 32'h2; tick();
    sts_in = 32'h3; repeat (3) tick();
    sb.push_back(32'h0000_0003);
    do_ack("stk_ack_lat");
    tick();
    check("coal_data", sts_data_out, 32'h3);
    check("coal_cnt",  32'(coalesce_count), 32'h2);
    coalesce_clr = 1'b1; tick(); coalesce_clr = 1'b0;
    check("coal_clr",  32'(coalesce_count), 32'h0);

    // Level bit 0 alone; sticky bit must not reappear.
    sts_in = 32'h1;
    sb.push_back(32'h0000_0001);
    repeat (2) tick();
    do_ack("coal_ack_lat");
    tick();
    check("bit0_data", sts_data_out, 32'h0000_0001);
    check("bit0_cnt",  32'(coalesce_count), 32'h0);
    do_ack("bit0_ack_lat");

    // Spurious ack toggles while IDLE are ignored.
    saved_req = sts_req_toggle;
    sts_ack_toggle = ~sts_ack_toggle;
    repeat (8) tick();
    check("spur_busy", 32'(busy), 32'h0);
    check("spur_req",  32'(sts_req_toggle), 32'(saved_req));
    sts_ack_toggle = ~sts_ack_toggle;
    repeat (8) tick();
    check("spur2_busy", 32'(busy), 32'h0);

    // Timeout: withheld ack, flag rises in the 16th WAIT_ACK cycle.
    sb.push_back(32'h0000_0007);
    sts_in = 32'h7;
    repeat (2) tick();
    saved_req = sts_req_toggle;
    check("tmo_c1", 32'(ack_timeout), 32'h0);
    repeat (TMO - 2) tick();
    check("tmo_c15", 32'(ack_timeout), 32'h0);
    tick();
    check("tmo_c16", 32'(ack_timeout), 32'h1);
    repeat (5) tick();
    check("tmo_busy", 32'(busy), 32'h1);
    check("tmo_req",  32'(sts_req_toggle), 32'(saved_req));
    do_ack("tmo_late_ack_lat");
    check("tmo_sticky", 32'(ack_timeout), 32'h1);

    // Reset in WAIT_ACK with bit 17 accumulated.
    sb.push_back(32'h0000_0008);
    sts_in = 32'h8;
    repeat (3) tick();
    sts_in = 32'h0002_0008; tick();
    sts_in = 32'h8;         repeat (2) tick();
    check("mid_busy_pre", 32'(busy), 32'h1);
    spi_reset = 1'b1;
    sts_ack_toggle = 1'b0;
    #1;
    check("mid_req",  32'(sts_req_toggle), 32'h0);
    check("mid_busy", 32'(busy), 32'h0);
    check("mid_data", sts_data_out, 32'h0);
    check("mid_tmo",  32'(ack_timeout), 32'h0);
    sts_in = 32'h0;
    repeat (2) tick();
    spi_reset = 1'b0;
    repeat (8) tick();
    check("post_busy", 32'(busy), 32'h0);
    check("post_data", sts_data_out, 32'h0);
    check("sb_drain",  32'(sb.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
